cache_ctrl: RTL

//  Miss-handling controller between the CPU load/store port, the direct-mapped

---
 rtl/cache_pkg.sv | 24 ++
 rtl/sat_counter.sv | 31 +++
 rtl/cache_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module : cache_pkg
// Brief  : Shared types and geometry constants for the cache miss controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        REFILL    = 3'd4
    } ctrl_state_t;

    localparam int LINE_BYTES = 4;
    localparam int TAG_LSB    = 13;
    localparam int IDX_LSB    = 2;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous clear.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
//------------------------------------------------------------------------------
// Module : cache_ctrl
// Brief  : Direct-mapped cache miss controller (write-back, fetch, refill).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_ctrl
    import cache_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int C_WIDTH = 13,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [XLEN-1:0]  cpu_addr,
    input  logic [XLEN-1:0]  cpu_wdata,
    output logic             cpu_ready,
    output logic [XLEN-1:0]  cpu_rdata,
    output logic [XLEN-1:0]  cache_addr,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    input  logic [XLEN-1:0]  cache_miss_addr,
    input  logic [XLEN-1:0]  cache_rdata,
    output logic             cache_we,
    output logic             cache_fill,
    output logic [XLEN-1:0]  cache_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int c_off_w = $clog2(LINE_BYTES);

    ctrl_state_t     r_state;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_fill_data;
    logic            r_retry;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    logic [XLEN-1:0] w_fetch_addr;
    logic            w_cmp_hit;
    logic            w_hit_en;
    logic            w_miss_en;

    // Tag and index of the latched request with the byte offset zeroed.
    assign w_fetch_addr = {r_addr[XLEN-1:TAG_LSB], r_addr[C_WIDTH-1:IDX_LSB], {c_off_w{1'b0}}};

    assign w_cmp_hit = (r_state == COMPARE) && cache_hit;
    assign w_hit_en  = w_cmp_hit && !r_retry;
    assign w_miss_en = (r_state == COMPARE) && !cache_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_fill_data <= '0;
            r_retry     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                        r_retry <= 1'b0;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cache_hit) begin
                        r_state <= IDLE;
                    end else if (cache_dirty) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cache_miss_addr;
                        r_mem_wdata <= cache_rdata;
                        r_state     <= WRITEBACK;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_fetch_addr;
                        r_state    <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (r_mem_req && mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // Arriving from a write-back, the fetch is issued one idle cycle later.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_fetch_addr;
                    end else if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_fill_data <= mem_rdata;
                        r_state     <= REFILL;
                    end
                end
                REFILL: begin
                    r_retry <= 1'b1;
                    r_state <= COMPARE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cpu_ready   = w_cmp_hit;
        cpu_rdata   = '0;
        cache_we    = 1'b0;
        cache_fill  = 1'b0;
        cache_wdata = '0;
        if (w_cmp_hit && !r_we) begin
            cpu_rdata = cache_rdata;
        end
        if (w_cmp_hit && r_we) begin
            cache_we    = 1'b1;
            cache_wdata = r_wdata;
        end
        if (r_state == REFILL) begin
            cache_we    = 1'b1;
            cache_fill  = 1'b1;
            cache_wdata = r_fill_data;
        end
    end

    assign cache_addr = r_addr;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .en    (w_hit_en),
        .clear (rst),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .en    (w_miss_en),
        .clear (rst),
        .count (miss_cnt)
    );

endmodule

`default_nettype wire
